// File: rtl/nios_dbg_pkg.sv
// rtl/nios_dbg_pkg.sv - shared types and constants for the debug command bridge
// Contents: default widths, virtual IR codes, pointer-width helper, and the
// command entry layout used by consumers of the default configuration.
package nios_dbg_pkg;

    localparam int DEF_SR_W  = 38;
    localparam int DEF_IR_W  = 2;
    localparam int DEF_TS_W  = 16;
    localparam int DEF_DEPTH = 4;

    localparam logic [DEF_IR_W-1:0] IR_OCIMEM_A  = 2'd0;
    localparam logic [DEF_IR_W-1:0] IR_OCIMEM_B  = 2'd1;
    localparam logic [DEF_IR_W-1:0] IR_BREAK     = 2'd2;
    localparam logic [DEF_IR_W-1:0] IR_TRACECTRL = 2'd3;

    // Pointer width for a power-of-two FIFO; never collapses to zero bits.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int PTR_W = ptr_w(DEF_DEPTH);

    typedef struct packed {
        logic [DEF_IR_W-1:0] ir;
        logic [DEF_SR_W-1:0] data;
        logic [DEF_TS_W-1:0] ts;
    } cmd_entry_t;

endpackage

// File: rtl/nios_dbg_sync_edge.sv
// rtl/nios_dbg_sync_edge.sv - strobe synchroniser with armed rising-edge detect
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   strobe       : level asynchronous to clk
//   rise         : one-cycle pulse per synchronised rising edge
module nios_dbg_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe,
    output logic rise
);

    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int CNT_W   = $clog2(ARM_MAX + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   dly;
    logic [CNT_W-1:0]       arm_cnt;
    logic                   armed;

    assign armed = (arm_cnt == CNT_W'(ARM_MAX));

    // The delay flop keeps following the synchroniser while unarmed, so a
    // level already high at reset release is seen as "old" once armed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync    <= '0;
            dly     <= 1'b0;
            arm_cnt <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], strobe};
            dly  <= sync[SYNC_STAGES-1];
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
        end
    end

    assign rise = armed & sync[SYNC_STAGES-1] & ~dly;

endmodule

// File: rtl/nios_dbg_cmd_sysclk_bridge.sv
// rtl/nios_dbg_cmd_sysclk_bridge.sv - JTAG debug command bridge into the system clock
// Optional feature macro: DBG_CMD_TIMESTAMP_EN (adds per-entry timestamp and cmd_ts).
// Ports:
//   clk, reset_n           : system clock, asynchronous active-low reset
//   vs_uir, vs_udr         : virtual UPDATE-IR / UPDATE-DR levels, async to clk
//   ir_in, sr              : virtual IR and shift register, quasi-static around updates
//   ir_update, ir_cur      : IR update pulse and IR captured at that pulse
//   cmd_valid/ready        : first-word fall-through command FIFO head handshake
//   cmd_ir, cmd_data       : head entry (held at last popped value when empty)
//   cmd_level              : registered occupancy 0..DEPTH
//   overflow, overflow_clr : sticky drop flag and its clear (set has priority)
//   cmd_ts                 : head timestamp (DBG_CMD_TIMESTAMP_EN only)
module nios_dbg_cmd_sysclk_bridge
    import nios_dbg_pkg::*;
#(
    parameter int SR_W        = DEF_SR_W,
    parameter int IR_W        = DEF_IR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = 2,
    parameter int TS_W        = DEF_TS_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       vs_uir,
    input  logic                       vs_udr,
    input  logic [IR_W-1:0]            ir_in,
    input  logic [SR_W-1:0]            sr,
    output logic                       ir_update,
    output logic [IR_W-1:0]            ir_cur,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [IR_W-1:0]            cmd_ir,
    output logic [SR_W-1:0]            cmd_data,
    output logic [$clog2(DEPTH):0]     cmd_level,
    output logic                       overflow,
`ifdef DBG_CMD_TIMESTAMP_EN
    output logic [TS_W-1:0]            cmd_ts,
`endif
    input  logic                       overflow_clr
);

    localparam int AW = ptr_w(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
`ifdef DBG_CMD_TIMESTAMP_EN
        logic [TS_W-1:0] ts;
`endif
    } entry_t;

    logic          uir_rise, udr_rise;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          full, pop, push, drop;
    entry_t        mem [DEPTH];
    entry_t        wr_entry, head, last_head;

    nios_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
        .clk(clk), .reset_n(reset_n), .strobe(vs_uir), .rise(uir_rise)
    );

    nios_dbg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
        .clk(clk), .reset_n(reset_n), .strobe(vs_udr), .rise(udr_rise)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_update <= 1'b0;
            ir_cur    <= '0;
        end else begin
            ir_update <= uir_rise;
            if (uir_rise) begin
                ir_cur <= ir_in;
            end
        end
    end

`ifdef DBG_CMD_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
        end
    end
`endif

    // ir_in rather than ir_cur: a simultaneous UIR/UDR must push the new IR.
    always_comb begin
        wr_entry      = '0;
        wr_entry.ir   = ir_in;
        wr_entry.data = sr;
`ifdef DBG_CMD_TIMESTAMP_EN
        wr_entry.ts   = ts_cnt;
`endif
    end

    assign cmd_valid = (level != '0);
    assign full      = (level == LW'(DEPTH));
    assign pop       = cmd_valid & cmd_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push      = udr_rise & (~full | pop);
    assign drop      = udr_rise & full & ~pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            last_head <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_head <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // When empty the head shows the entry most recently consumed.
    assign head      = cmd_valid ? mem[rd_ptr] : last_head;
    assign cmd_ir    = head.ir;
    assign cmd_data  = head.data;
    assign cmd_level = level;
`ifdef DBG_CMD_TIMESTAMP_EN
    assign cmd_ts    = head.ts;
`endif

endmodule

// File: tb/tb_nios_dbg_cmd_sysclk_bridge.sv
// tb/tb_nios_dbg_cmd_sysclk_bridge.sv - self-checking bench for the debug command bridge
module tb_nios_dbg_cmd_sysclk_bridge;
    import nios_dbg_pkg::*;

    localparam int SR_W  = 38;
    localparam int IR_W  = 2;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            vs_uir = 1'b0;
    logic            vs_udr = 1'b0;
    logic            cmd_ready = 1'b0;
    logic            overflow_clr = 1'b0;
    logic [IR_W-1:0] ir_in = '0;
    logic [SR_W-1:0] sr = '0;
    logic            ir_update, cmd_valid, overflow;
    logic [IR_W-1:0] ir_cur, cmd_ir;
    logic [SR_W-1:0] cmd_data;
    logic [LW-1:0]   cmd_level;
`ifdef DBG_CMD_TIMESTAMP_EN
    logic [15:0]     cmd_ts;
`endif

    nios_dbg_cmd_sysclk_bridge dut (
        .clk(clk), .reset_n(reset_n), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in), .sr(sr), .ir_update(ir_update), .ir_cur(ir_cur),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
        .cmd_data(cmd_data), .cmd_level(cmd_level), .overflow(overflow),
`ifdef DBG_CMD_TIMESTAMP_EN
        .cmd_ts(cmd_ts),
`endif
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] data;
    } ent_t;

    ent_t q[$];
    bit   m_ovf = 1'b0;

    typedef struct {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] sr;
        logic [LW-1:0]   exp_level;
        logic            exp_ovf;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise the requested strobes, hold long enough to pass the synchroniser, drop, settle.
    task automatic strobe(input bit u_ir, input bit u_dr);
        vs_uir = u_ir;
        vs_udr = u_dr;
        repeat (4) tick();
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        repeat (4) tick();
    endtask

    task automatic model_push(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d);
        ent_t e;
        e.ir = ir;
        e.data = d;
        if (q.size() < DEPTH) q.push_back(e);
        else m_ovf = 1'b1;
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (cmd_valid) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic drain_check(input string name);
        cmd_ready = 1'b1;
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            if (cmd_valid) begin
                chk({name, "_ir"}, 64'(cmd_ir), 64'(q[0].ir));
                chk({name, "_data"}, 64'(cmd_data), 64'(q[0].data));
                void'(q.pop_front());
            end
            tick();
        end
        cmd_ready = 1'b0;
        chk({name, "_all_drained"}, 64'(q.size()), 64'd0);
        chk({name, "_level_zero"}, 64'(cmd_level), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int bad;
        logic [SR_W-1:0] rnd_sr;

        vt[0] = '{ir: 2'd0, sr: 38'h01_1111_0001, exp_level: 3'd1, exp_ovf: 1'b0};
        vt[1] = '{ir: 2'd1, sr: 38'h02_2222_0002, exp_level: 3'd2, exp_ovf: 1'b0};
        vt[2] = '{ir: 2'd2, sr: 38'h03_3333_0003, exp_level: 3'd3, exp_ovf: 1'b0};
        vt[3] = '{ir: 2'd3, sr: 38'h04_4444_0004, exp_level: 3'd4, exp_ovf: 1'b0};
        vt[4] = '{ir: 2'd1, sr: 38'h05_5555_0005, exp_level: 3'd4, exp_ovf: 1'b1};

        // Reset with vs_udr already high: nothing may be captured after release.
        vs_udr = 1'b1;
        repeat (3) tick();
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_cmd_level", 64'(cmd_level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_ir_cur", 64'(ir_cur), 64'd0);
        chk("rst_ir_update", 64'(ir_update), 64'd0);
        chk("rst_cmd_ir", 64'(cmd_ir), 64'd0);
        chk("rst_cmd_data", 64'(cmd_data), 64'd0);
        reset_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (cmd_valid || ir_update) bad++;
        end
        chk("held_udr_no_event", 64'(bad), 64'd0);
        chk("held_udr_level", 64'(cmd_level), 64'd0);
        vs_udr = 1'b0;
        repeat (4) tick();

        // UIR then UDR, latency SYNC_STAGES+1 sampled edges for each.
        ir_in = IR_BREAK;
        vs_uir = 1'b1;
        n = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (ir_update) begin
                n = c;
                break;
            end
        end
        chk("uir_latency", 64'(n), 64'd3);
        chk("uir_ir_cur", 64'(ir_cur), 64'd2);
        tick();
        chk("uir_pulse_one_cycle", 64'(ir_update), 64'd0);
        vs_uir = 1'b0;
        repeat (4) tick();
        sr = 38'h2A_DEAD_BEEF;
        vs_udr = 1'b1;
        wait_valid(n);
        chk("udr_latency", 64'(n), 64'd3);
        chk("udr_cmd_ir", 64'(cmd_ir), 64'd2);
        chk("udr_cmd_data", 64'(cmd_data), 64'h2A_DEAD_BEEF);
        vs_udr = 1'b0;
        repeat (4) tick();
        chk("udr_level_one", 64'(cmd_level), 64'd1);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("pop_empty_valid", 64'(cmd_valid), 64'd0);
        chk("pop_head_hold_data", 64'(cmd_data), 64'h2A_DEAD_BEEF);
        chk("pop_head_hold_ir", 64'(cmd_ir), 64'd2);

        // Simultaneous UIR and UDR edges: push must carry the new ir_in.
        ir_in = IR_OCIMEM_B;
        sr = 38'h3F_0BAD_F00D;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        wait_valid(n);
        chk("both_latency", 64'(n), 64'd3);
        chk("both_ir_update", 64'(ir_update), 64'd1);
        chk("both_cmd_ir_new", 64'(cmd_ir), 64'd1);
        chk("both_ir_cur", 64'(ir_cur), 64'd1);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        repeat (4) tick();
        q.delete();
        model_push(IR_OCIMEM_B, 38'h3F_0BAD_F00D);
        drain_check("both_drain");

        // Table: five captures into a four-deep FIFO, fifth dropped.
        for (int i = 0; i < 5; i++) begin
            ir_in = vt[i].ir;
            sr = vt[i].sr;
            strobe(1'b0, 1'b1);
            model_push(vt[i].ir, vt[i].sr);
            chk($sformatf("tbl%0d_level", i), 64'(cmd_level), 64'(vt[i].exp_level));
            chk($sformatf("tbl%0d_overflow", i), 64'(overflow), 64'(vt[i].exp_ovf));
        end
        drain_check("tbl_drain");
        repeat (3) tick();
        chk("tbl_fifth_lost", 64'(cmd_valid), 64'd0);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("tbl_ovf_clear", 64'(overflow), 64'd0);

        // Full FIFO: push and pop in the same cycle.
        q.delete();
        for (int i = 0; i < 4; i++) begin
            ir_in = 2'(i);
            sr = 38'h10_0000_0000 + 38'(i);
            strobe(1'b0, 1'b1);
            model_push(2'(i), 38'h10_0000_0000 + 38'(i));
        end
        chk("pp_full_level", 64'(cmd_level), 64'd4);
        ir_in = 2'd3;
        sr = 38'h15_0000_1234;
        vs_udr = 1'b1;
        tick();
        tick();
        chk("pp_head_before", 64'(cmd_data), 64'(q[0].data));
        void'(q.pop_front());
        model_push(2'd3, 38'h15_0000_1234);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        chk("pp_level_stays", 64'(cmd_level), 64'd4);
        chk("pp_no_overflow", 64'(overflow), 64'd0);
        vs_udr = 1'b0;
        repeat (4) tick();

        // Overflow set beats a simultaneous clear; clear alone then works.
        sr = 38'h00_0000_0BAD;
        strobe(1'b0, 1'b1);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_level", 64'(cmd_level), 64'd4);
        vs_udr = 1'b1;
        tick();
        tick();
        overflow_clr = 1'b1;
        tick();
        chk("ovf_set_wins", 64'(overflow), 64'd1);
        tick();
        overflow_clr = 1'b0;
        chk("ovf_clr_alone", 64'(overflow), 64'd0);
        vs_udr = 1'b0;
        repeat (4) tick();
        drain_check("pp_drain");

        // Reset in the middle of a drain.
        ir_in = 2'd2;
        sr = 38'h0A_AAAA_AAAA;
        strobe(1'b0, 1'b1);
        sr = 38'h0B_BBBB_BBBB;
        strobe(1'b0, 1'b1);
        chk("mid_level_two", 64'(cmd_level), 64'd2);
        cmd_ready = 1'b1;
        tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(cmd_valid), 64'd0);
        chk("mid_rst_level", 64'(cmd_level), 64'd0);
        cmd_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        q.delete();
        ir_in = 2'd0;
        sr = 38'h0C_CCCC_CCCC;
        strobe(1'b0, 1'b1);
        model_push(2'd0, 38'h0C_CCCC_CCCC);
        chk("mid_one_entry", 64'(cmd_level), 64'd1);
        drain_check("mid_drain");
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (cmd_valid) bad++;
        end
        chk("mid_no_extra", 64'(bad), 64'd0);

        // Randomized operations against the queue model.
        q.delete();
        m_ovf = 1'b0;
        for (int op_i = 0; op_i < 60; op_i++) begin
            int op;
            op = $urandom_range(0, 3);
            if (op <= 1) begin
                ir_in = 2'($urandom());
                rnd_sr = SR_W'({$urandom(), $urandom()});
                sr = rnd_sr;
                strobe(1'b0, 1'b1);
                model_push(ir_in, rnd_sr);
                chk("rnd_push_level", 64'(cmd_level), 64'(q.size()));
                chk("rnd_push_ovf", 64'(overflow), 64'(m_ovf));
            end else if (op == 2) begin
                logic [IR_W-1:0] new_ir;
                new_ir = 2'($urandom());
                ir_in = new_ir;
                strobe(1'b1, 1'b0);
                chk("rnd_ir_cur", 64'(ir_cur), 64'(new_ir));
            end else begin
                overflow_clr = 1'b1;
                tick();
                overflow_clr = 1'b0;
                m_ovf = 1'b0;
                chk("rnd_ovf_clr", 64'(overflow), 64'd0);
                for (int c = 0; c < 10; c++) begin
                    cmd_ready = 1'($urandom_range(0, 1));
                    chk("rnd_valid", 64'(cmd_valid), 64'(q.size() != 0));
                    if (cmd_valid && cmd_ready && q.size() > 0) begin
                        chk("rnd_pop_ir", 64'(cmd_ir), 64'(q[0].ir));
                        chk("rnd_pop_data", 64'(cmd_data), 64'(q[0].data));
                        void'(q.pop_front());
                    end
                    tick();
                end
                cmd_ready = 1'b0;
                chk("rnd_drain_level", 64'(cmd_level), 64'(q.size()));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
